// File: rtl/fft_job_arbiter.sv
// Round-robin arbiter that lends a single FFT core to NREQ requesters, one job at a time,
// with a RUN watchdog that aborts jobs whose core never reports completion.
//
// state | meaning
// IDLE  | no job; searching req from last_gnt+1 for the next owner
// START | owner latched; core_start pulse
// RUN   | waiting for core_done or the watchdog terminal count
// RESP  | rsp_valid/rsp_err pulse to owner; last_gnt updated
module fft_job_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64,
  parameter int SELW    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            core_done,
  output logic [NREQ-1:0] gnt,
  output logic [SELW-1:0] sel_idx,
  output logic            core_start,
  output logic [NREQ-1:0] rsp_valid,
  output logic            rsp_err,
  output logic            busy,
  output logic [15:0]     job_count
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, RUN, RESP} state_t;

  state_t          state_q;
  logic [NREQ-1:0] gnt_q;
  logic [SELW-1:0] sel_idx_q;
  logic [SELW-1:0] last_gnt_q;
  logic            core_start_q;
  logic [NREQ-1:0] rsp_valid_q;
  logic            rsp_err_q;
  logic            busy_q;
  logic [15:0]     job_count_q;
  logic [TW-1:0]   timer_q;

  logic [SELW-1:0] pick_idx_d;
  logic [SELW-1:0] cand_d;
  logic            pick_hit_d;
  logic [NREQ-1:0] pick_gnt_d;

  // Cyclic search starting just after the previous owner; the previous owner is tried last.
  always_comb begin
    pick_idx_d = last_gnt_q;
    cand_d     = last_gnt_q;
    pick_hit_d = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      cand_d = SELW'((int'(last_gnt_q) + i) % NREQ);
      if (!pick_hit_d && req[cand_d]) begin
        pick_hit_d = 1'b1;
        pick_idx_d = cand_d;
      end
    end
  end

  assign pick_gnt_d = NREQ'(1) << pick_idx_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      sel_idx_q    <= '0;
      last_gnt_q   <= SELW'(NREQ - 1);
      core_start_q <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      job_count_q  <= '0;
      timer_q      <= '0;
    end else begin
      core_start_q <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_err_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req != '0) begin
            state_q      <= START;
            gnt_q        <= pick_gnt_d;
            sel_idx_q    <= pick_idx_d;
            core_start_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        START: begin
          state_q <= RUN;
          timer_q <= '0;
        end
        RUN: begin
          // done is tested first so it wins over a coincident watchdog expiry
          if (core_done) begin
            state_q     <= RESP;
            rsp_valid_q <= gnt_q;
            rsp_err_q   <= 1'b0;
          end else if (timer_q == TIMER_LAST) begin
            state_q     <= RESP;
            rsp_valid_q <= gnt_q;
            rsp_err_q   <= 1'b1;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        RESP: begin
          state_q    <= IDLE;
          gnt_q      <= '0;
          busy_q     <= 1'b0;
          last_gnt_q <= sel_idx_q;
          if (!rsp_err_q) job_count_q <= job_count_q + 16'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt        = gnt_q;
  assign sel_idx    = sel_idx_q;
  assign core_start = core_start_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = busy_q;
  assign job_count  = job_count_q;

endmodule

// File: tb/tb_fft_job_arbiter.sv
// Scoreboard bench for fft_job_arbiter: a job-level model predicts owner, start cycle,
// response cycle, error flag and job count; a monitor compares whenever the DUT pulses.
module tb_fft_job_arbiter;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 64;
  localparam int SELW    = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] req;
  logic            core_done;
  logic [NREQ-1:0] gnt;
  logic [SELW-1:0] sel_idx;
  logic            core_start;
  logic [NREQ-1:0] rsp_valid;
  logic            rsp_err;
  logic            busy;
  logic [15:0]     job_count;

  fft_job_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .SELW(SELW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .core_done(core_done),
    .gnt(gnt), .sel_idx(sel_idx), .core_start(core_start),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .busy(busy), .job_count(job_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int              cycle;
    logic [NREQ-1:0] onehot;
    int              idx;
    logic            err;
    logic [15:0]     cnt;
  } exp_t;

  exp_t start_q[$];
  exp_t rsp_q[$];

  int          n_pass = 0;
  int          n_total = 0;
  int          last_win;
  logic [15:0] model_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Owner = set requester with the smallest cyclic distance past the previous owner.
  function automatic int pick(input logic [NREQ-1:0] pat, input int last);
    int best, bestd, d;
    best  = -1;
    bestd = NREQ + 1;
    for (int i = 0; i < NREQ; i++) begin
      d = (i - last - 1 + 2 * NREQ) % NREQ;
      if (pat[i] && d < bestd) begin
        bestd = d;
        best  = i;
      end
    end
    return best;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int idx);
    logic [NREQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Monitor
  exp_t        me;
  bit          cnt_pending = 1'b0;
  logic [15:0] cnt_exp;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cnt_pending = 1'b0;
      end else begin
        if (cnt_pending) begin
          check("job_count", 32'(job_count), 32'(cnt_exp));
          cnt_pending = 1'b0;
        end
        if (start_q.size() > 0 && start_q[0].cycle < cyc) begin
          check("start_missing_cycle", 32'(cyc), 32'(start_q[0].cycle));
          void'(start_q.pop_front());
        end
        if (rsp_q.size() > 0 && rsp_q[0].cycle < cyc) begin
          check("rsp_missing_cycle", 32'(cyc), 32'(rsp_q[0].cycle));
          void'(rsp_q.pop_front());
        end
        if (core_start) begin
          if (start_q.size() == 0) begin
            check("start_unexpected", 32'(core_start), 32'(0));
          end else begin
            me = start_q.pop_front();
            check("start_cycle", 32'(cyc), 32'(me.cycle));
            check("start_gnt", 32'(gnt), 32'(me.onehot));
            check("start_sel_idx", 32'(sel_idx), 32'(me.idx));
            check("start_busy", 32'(busy), 32'(1));
          end
        end
        if (rsp_valid != '0) begin
          if (rsp_q.size() == 0) begin
            check("rsp_unexpected", 32'(rsp_valid), 32'(0));
          end else begin
            me = rsp_q.pop_front();
            check("rsp_cycle", 32'(cyc), 32'(me.cycle));
            check("rsp_valid", 32'(rsp_valid), 32'(me.onehot));
            check("rsp_err", 32'(rsp_err), 32'(me.err));
            check("rsp_gnt_held", 32'(gnt), 32'(me.onehot));
            check("rsp_sel_held", 32'(sel_idx), 32'(me.idx));
            cnt_exp     = me.cnt;
            cnt_pending = 1'b1;
          end
        end
      end
    end
  end

  // Entered at posedge+1 of a cycle in which the DUT is idle; returns likewise.
  // done_k: RUN cycle index carrying core_done (>= TIMEOUT means never).
  // drop_k: RUN cycle index at which req is forced to 0 (-1 for none).
  task automatic run_job(input logic [NREQ-1:0] pat, input int done_k, input int drop_k,
                         input bit scramble);
    int   c, w, rc;
    logic err;
    c   = cyc;
    w   = pick(pat, last_win);
    err = (done_k >= TIMEOUT);
    rc  = err ? c + 2 + TIMEOUT : c + 3 + done_k;
    if (!err) model_cnt = model_cnt + 16'd1;
    start_q.push_back('{cycle: c + 1, onehot: onehot(w), idx: w, err: 1'b0, cnt: 16'd0});
    rsp_q.push_back('{cycle: rc, onehot: onehot(w), idx: w, err: err, cnt: model_cnt});
    last_win = w;
    req       = pat;
    core_done = scramble ? 1'($urandom_range(0, 1)) : 1'b0;
    @(negedge clk);
    check("idle_gnt", 32'(gnt), 32'(0));
    check("idle_busy", 32'(busy), 32'(0));
    @(posedge clk) #1;
    core_done = scramble ? 1'($urandom_range(0, 1)) : 1'b0;
    if (scramble) req = NREQ'($urandom);
    for (int k = 0; k < TIMEOUT; k++) begin
      @(posedge clk) #1;
      core_done = (k == done_k);
      if (k == drop_k) req = '0;
      else if (scramble) req = NREQ'($urandom);
      if (k == done_k || k == TIMEOUT - 1) break;
    end
    @(posedge clk) #1;
    core_done = scramble ? 1'($urandom_range(0, 1)) : 1'b0;
    req       = scramble ? NREQ'($urandom) : '0;
    @(posedge clk) #1;
    core_done = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    req = '0;
    for (int i = 0; i < n; i++) begin
      core_done = 1'($urandom_range(0, 1));
      @(posedge clk) #1;
    end
    core_done = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 32'(0));
    check({tag, "_sel_idx"}, 32'(sel_idx), 32'(0));
    check({tag, "_core_start"}, 32'(core_start), 32'(0));
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(0));
    check({tag, "_rsp_err"}, 32'(rsp_err), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_job_count"}, 32'(job_count), 32'(0));
  endtask

  initial begin
    int dk, pat;
    rst_n     = 1'b0;
    req       = '0;
    core_done = 1'b0;
    last_win  = NREQ - 1;
    model_cnt = 16'd0;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Full contention: round-robin 0,1,2,3,0 with one idle cycle between jobs
    for (int j = 0; j < 5; j++) run_job(4'b1111, 2, -1, 1'b0);
    // Single requester, done 4 cycles after start
    run_job(4'b0100, 3, -1, 1'b0);
    // Watchdog expiry
    run_job(4'b0001, TIMEOUT + 10, -1, 1'b0);
    // Done on the terminal-count cycle wins
    run_job(4'b0001, TIMEOUT - 1, -1, 1'b0);
    // Requester withdraws during RUN
    run_job(4'b0010, 5, 2, 1'b0);

    for (int j = 0; j < 30; j++) begin
      pat = $urandom_range(1, (1 << NREQ) - 1);
      case ($urandom_range(0, 9))
        0:       dk = TIMEOUT + 1;
        1:       dk = TIMEOUT - 1;
        2:       dk = TIMEOUT - 2;
        default: dk = $urandom_range(0, 10);
      endcase
      run_job(NREQ'(pat), dk, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1, 1'b1);
      idle_cycles($urandom_range(0, 2));
    end

    // Reset mid-RUN while requester 3 owns the core
    req       = 4'b1000;
    core_done = 1'b0;
    start_q.push_back('{cycle: cyc + 1, onehot: onehot(3), idx: 3, err: 1'b0, cnt: 16'd0});
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    req   = 4'b1010;
    start_q.delete();
    rsp_q.delete();
    last_win  = NREQ - 1;
    model_cnt = 16'd0;
    #1;
    check_all_zero("midjob_reset");
    @(posedge clk) #1;
    @(posedge clk) #1;
    rst_n = 1'b1;
    run_job(4'b1010, 3, -1, 1'b0);
    run_job(4'b1010, 1, -1, 1'b0);

    idle_cycles(TIMEOUT + 8);
    check("start_queue_drained", 32'(start_q.size()), 32'(0));
    check("rsp_queue_drained", 32'(rsp_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fft_job_arbiter.md
FFT_JOB_ARBITER -- requirements
Module: fft_job_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters sharing one FFT core (2..8).
REQ-002 The block SHALL have parameter TIMEOUT, default 64, giving the maximum RUN cycles allowed before a job is aborted (>=2).
REQ-003 The block SHALL have parameter SELW, default 2, giving the width of sel_idx; SELW = ceil(log2(NREQ)).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low; ports SHALL be named clk and rst_n.
REQ-005 Ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req  in  NREQ  level request per requester
- core_done  in  1  FFT core completion pulse
- gnt  out  NREQ  one-hot grant to the owning requester
- sel_idx  out  SELW  index of owner; drives core input data mux
- core_start  out  1  one-cycle start pulse to FFT core
- rsp_valid  out  NREQ  one-hot, one-cycle completion pulse to owner
- rsp_err  out  1  qualifies rsp_valid; 1 = job timed out
- busy  out  1  high whenever state is not IDLE
- job_count  out  16  count of successfully completed jobs

Function
REQ-006 The FSM SHALL have states IDLE, START, RUN and RESP, each lasting one cycle except RUN.
REQ-007 In IDLE with req != 0, the block SHALL pick the first set req bit searching cyclically from last_gnt+1, register gnt/sel_idx and go to START; with req == 0 it SHALL stay in IDLE.
REQ-008 In START, core_start SHALL be 1 for exactly that cycle; the RUN timer SHALL clear to 0; next state RUN.
REQ-009 In RUN, if core_done=1 the block SHALL go to RESP with err=0; else if timer == TIMEOUT-1 it SHALL go to RESP with err=1; else timer increments.
REQ-010 If core_done and the timeout occur in the same cycle, done SHALL win (err=0).
REQ-011 core_done SHALL be ignored in IDLE, START and RESP.
REQ-012 In RESP, rsp_valid SHALL equal gnt for one cycle, with rsp_err=err; last_gnt SHALL be updated to sel_idx; next state IDLE.
REQ-013 In RESP with err=0, job_count SHALL increment by 1, wrapping 0xFFFF to 0; timed-out jobs SHALL NOT count.
REQ-014 gnt and sel_idx SHALL be held constant from START through RESP; gnt SHALL be 0 in IDLE; sel_idx SHALL hold its last value in IDLE.
REQ-015 A requester deasserting req after grant SHALL NOT abort the job; the response SHALL still be delivered.
REQ-016 Timing SHALL be: req seen in IDLE at cycle t gives gnt and core_start at t+1, and a done pulse at cycle d gives rsp_valid at d+1; there SHALL be at least one IDLE cycle between jobs.
REQ-017 All outputs SHALL be registered or decoded from registered state only, with no combinational path from req or core_done to any output.

Reset
REQ-018 While rst_n=0: state=IDLE, gnt=0, sel_idx=0, core_start=0, rsp_valid=0, rsp_err=0, busy=0, job_count=0, timer=0, last_gnt=NREQ-1 (requester 0 has first priority).
REQ-019 Reset asserted mid-job SHALL abort it immediately with no rsp_valid pulse; operation resumes from IDLE on the first clock edge after release.

Verification
REQ-020 req=4'b0100 only, core_done 4 cycles after core_start -> gnt=4'b0100, sel_idx=2, one core_start pulse, rsp_valid=4'b0100 with rsp_err=0 the cycle after done, job_count=1.
REQ-021 req=4'b1111 held, done 3 cycles after each start -> grant order 0,1,2,3,0; exactly one IDLE cycle between each RESP and the next START.
REQ-022 req=4'b0001, core_done never asserted, TIMEOUT=64 -> rsp_valid=4'b0001 with rsp_err=1 exactly 65 cycles after the core_start cycle; job_count unchanged.
REQ-023 core_done asserted on RUN cycle with timer=TIMEOUT-1 -> rsp_err=0, job_count increments.
REQ-024 rst_n pulsed low during RUN for requester 3 -> all outputs 0 at once, no rsp_valid; after release with req=4'b1010 -> gnt=4'b0010 first.
REQ-025 req[1] dropped to 0 two cycles into RUN -> gnt[1] held, rsp_valid[1] still pulses after core_done.
